// File: rtl/axi_lite_to_ipif_pkg.sv
// Shared types and constants for the AXI4-Lite to IPIF bridge.
package nf10_ipif_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_BUS,
    ST_RD_BUS,
    ST_WR_RESP,
    ST_RD_RESP
  } state_e;

  localparam logic [1:0]  AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0]  AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0]  AXI_RESP_DECERR = 2'b11;
  localparam logic [31:0] DEAD_BEEF       = 32'hDEAD_BEEF;

endpackage

// File: rtl/axi_lite_to_ipif_if.sv
// AXI4-Lite slave channels plus IPIF request/completion signals of the bridge.
interface axi_lite_to_ipif_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
);
  logic [ADDR_W-1:0]   s_axi_awaddr;
  logic                s_axi_awvalid;
  logic                s_axi_awready;
  logic [DATA_W-1:0]   s_axi_wdata;
  logic [DATA_W/8-1:0] s_axi_wstrb;
  logic                s_axi_wvalid;
  logic                s_axi_wready;
  logic [1:0]          s_axi_bresp;
  logic                s_axi_bvalid;
  logic                s_axi_bready;
  logic [ADDR_W-1:0]   s_axi_araddr;
  logic                s_axi_arvalid;
  logic                s_axi_arready;
  logic [DATA_W-1:0]   s_axi_rdata;
  logic [1:0]          s_axi_rresp;
  logic                s_axi_rvalid;
  logic                s_axi_rready;
  logic [ADDR_W-1:0]   bus2ip_addr;
  logic                bus2ip_cs;
  logic                bus2ip_rnw;
  logic [DATA_W-1:0]   bus2ip_data;
  logic [DATA_W/8-1:0] bus2ip_be;
  logic [DATA_W-1:0]   ip2bus_data;
  logic                ip2bus_rdack;
  logic                ip2bus_wrack;
  logic                ip2bus_error;

  // Bridge view: AXI slave on one side, IPIF master on the other.
  modport slave (
    input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
           s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
           ip2bus_data, ip2bus_rdack, ip2bus_wrack, ip2bus_error,
    output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
           s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid,
           bus2ip_addr, bus2ip_cs, bus2ip_rnw, bus2ip_data, bus2ip_be
  );

  modport master (
    output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
           s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
           ip2bus_data, ip2bus_rdack, ip2bus_wrack, ip2bus_error,
    input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
           s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid,
           bus2ip_addr, bus2ip_cs, bus2ip_rnw, bus2ip_data, bus2ip_be
  );
endinterface

// File: rtl/axi_lite_to_ipif_ack_timer.sv
// Clearable cycle counter flagging when an IPIF ack wait has run its full budget.
module ipif_ack_timer #(
  parameter int unsigned C_TIMEOUT_CYCLES = 64
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  output logic expired_o
);
  localparam int unsigned CW = $clog2(C_TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = clr_i ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign expired_o = (cnt_q == CW'(C_TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/axi_lite_to_ipif.sv
// AXI4-Lite slave to IPIF master bridge, one transaction at a time.
// Optional ack timeout enabled by defining IPIF_TIMEOUT_EN.
module axi_lite_to_ipif
  import nf10_ipif_pkg::*;
#(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 32,
  parameter logic [C_S_AXI_ADDR_WIDTH-1:0] C_BASEADDR = 32'hFFFF_FFFF,
  parameter logic [C_S_AXI_ADDR_WIDTH-1:0] C_HIGHADDR = 32'h0000_0000,
  parameter int unsigned C_TIMEOUT_CYCLES   = 64
) (
  input  logic               s_axi_aclk,
  input  logic               s_axi_areset,
  axi_lite_to_ipif_if.slave  io
);
  localparam int unsigned DW = C_S_AXI_DATA_WIDTH;
  localparam int unsigned AW = C_S_AXI_ADDR_WIDTH;
  localparam int unsigned BW = DW / 8;

  state_e          state_q, state_d;
  logic            last_wr_q, last_wr_d;
  logic            bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic [1:0]      bresp_q, bresp_d, rresp_q, rresp_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            cs_q, cs_d, rnw_q, rnw_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   data_q, data_d;
  logic [BW-1:0]   be_q, be_d;
  logic            grant_rd, grant_wr, timeout;

  function automatic logic in_range(input logic [AW-1:0] a);
    return (a >= C_BASEADDR) && (a <= C_HIGHADDR);
  endfunction

`ifdef IPIF_TIMEOUT_EN
  logic tmr_clr;
  assign tmr_clr = !((state_q == ST_WR_BUS) || (state_q == ST_RD_BUS));

  ipif_ack_timer #(.C_TIMEOUT_CYCLES(C_TIMEOUT_CYCLES)) u_ack_timer (
    .clk_i     (s_axi_aclk),
    .rst_i     (s_axi_areset),
    .clr_i     (tmr_clr),
    .expired_o (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  // Readies are combinational so the handshake lands in the decision cycle;
  // they are masked during reset so nothing is accepted while held.
  always_comb begin
    grant_rd = !s_axi_areset && (state_q == ST_IDLE) && io.s_axi_arvalid &&
               (!(io.s_axi_awvalid && io.s_axi_wvalid) || last_wr_q);
    grant_wr = !s_axi_areset && (state_q == ST_IDLE) && !grant_rd &&
               io.s_axi_awvalid && io.s_axi_wvalid;
  end

  always_comb begin
    state_d   = state_q;
    last_wr_d = last_wr_q;
    bvalid_d  = bvalid_q;
    rvalid_d  = rvalid_q;
    bresp_d   = bresp_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    cs_d      = cs_q;
    rnw_d     = rnw_q;
    addr_d    = addr_q;
    data_d    = data_q;
    be_d      = be_q;
    unique case (state_q)
      ST_IDLE: begin
        if (grant_rd) begin
          last_wr_d = 1'b0;
          addr_d    = io.s_axi_araddr;
          rnw_d     = 1'b1;
          be_d      = '1;
          if (in_range(io.s_axi_araddr)) begin
            cs_d    = 1'b1;
            state_d = ST_RD_BUS;
          end else begin
            rresp_d  = AXI_RESP_DECERR;
            rdata_d  = '0;
            rvalid_d = 1'b1;
            state_d  = ST_RD_RESP;
          end
        end else if (grant_wr) begin
          last_wr_d = 1'b1;
          addr_d    = io.s_axi_awaddr;
          data_d    = io.s_axi_wdata;
          be_d      = io.s_axi_wstrb;
          rnw_d     = 1'b0;
          if (in_range(io.s_axi_awaddr)) begin
            cs_d    = 1'b1;
            state_d = ST_WR_BUS;
          end else begin
            bresp_d  = AXI_RESP_DECERR;
            bvalid_d = 1'b1;
            state_d  = ST_WR_RESP;
          end
        end
      end
      ST_WR_BUS: begin
        if (io.ip2bus_wrack || timeout) begin
          cs_d     = 1'b0;
          bvalid_d = 1'b1;
          bresp_d  = (!io.ip2bus_wrack || io.ip2bus_error) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
          state_d  = ST_WR_RESP;
        end
      end
      ST_RD_BUS: begin
        if (io.ip2bus_rdack || timeout) begin
          cs_d     = 1'b0;
          rvalid_d = 1'b1;
          rdata_d  = io.ip2bus_rdack ? io.ip2bus_data : DW'(DEAD_BEEF);
          rresp_d  = (!io.ip2bus_rdack || io.ip2bus_error) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
          state_d  = ST_RD_RESP;
        end
      end
      ST_WR_RESP: begin
        if (io.s_axi_bready) begin
          bvalid_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      ST_RD_RESP: begin
        if (io.s_axi_rready) begin
          rvalid_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      state_q   <= ST_IDLE;
      last_wr_q <= 1'b1;
      bvalid_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      bresp_q   <= '0;
      rresp_q   <= '0;
      rdata_q   <= '0;
      cs_q      <= 1'b0;
      rnw_q     <= 1'b1;
      addr_q    <= '0;
      data_q    <= '0;
      be_q      <= '0;
    end else begin
      state_q   <= state_d;
      last_wr_q <= last_wr_d;
      bvalid_q  <= bvalid_d;
      rvalid_q  <= rvalid_d;
      bresp_q   <= bresp_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
      cs_q      <= cs_d;
      rnw_q     <= rnw_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      be_q      <= be_d;
    end
  end

  assign io.s_axi_arready = grant_rd;
  assign io.s_axi_awready = grant_wr;
  assign io.s_axi_wready  = grant_wr;
  assign io.s_axi_bvalid  = bvalid_q;
  assign io.s_axi_bresp   = bresp_q;
  assign io.s_axi_rvalid  = rvalid_q;
  assign io.s_axi_rresp   = rresp_q;
  assign io.s_axi_rdata   = rdata_q;
  assign io.bus2ip_cs     = cs_q;
  assign io.bus2ip_rnw    = rnw_q;
  assign io.bus2ip_addr   = addr_q;
  assign io.bus2ip_data   = data_q;
  assign io.bus2ip_be     = be_q;
endmodule

// File: tb/tb_axi_lite_to_ipif.sv
// Self-checking bench for axi_lite_to_ipif: AXI master driver, IPIF slave responder, memory model.
module tb_axi_lite_to_ipif;
  localparam logic [31:0] BASE = 32'h0000_0100;
  localparam logic [31:0] HIGH = 32'h0000_01FF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  axi_lite_to_ipif_if #(.DATA_W(32), .ADDR_W(32)) bus ();

  axi_lite_to_ipif #(
    .C_S_AXI_DATA_WIDTH (32),
    .C_S_AXI_ADDR_WIDTH (32),
    .C_BASEADDR         (BASE),
    .C_HIGHADDR         (HIGH),
    .C_TIMEOUT_CYCLES   (8)
  ) dut (
    .s_axi_aclk   (clk),
    .s_axi_areset (rst),
    .io           (bus)
  );

  typedef struct {
    logic [31:0] addr;
    logic        rnw;
    logic [31:0] data;
    logic [3:0]  be;
    int          len;
  } ep_t;

  ep_t         eps[$];
  int          sl_delay = 1;
  logic        sl_err   = 1'b0;
  logic        sl_stray = 1'b0;
  logic [31:0] smem [logic [31:0]];
  logic [31:0] mmem [logic [31:0]];

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    return mmem.exists(a) ? mmem[a] : dflt(a);
  endfunction

  function automatic void model_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] v;
    v = model_rd(a);
    for (int i = 0; i < 4; i++) if (s[i]) v[8*i +: 8] = d[8*i +: 8];
    mmem[a] = v;
  endfunction

  // IPIF slave: acks on the sl_delay-th cycle of cs; sl_delay==0 never acks.
  initial begin : ipif_slave
    ep_t cur;
    logic cs_prev, ack;
    logic [31:0] v;
    cur = '{addr: '0, rnw: 1'b0, data: '0, be: '0, len: 0};
    cs_prev = 1'b0;
    bus.ip2bus_data = '0; bus.ip2bus_rdack = 1'b0;
    bus.ip2bus_wrack = 1'b0; bus.ip2bus_error = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.bus2ip_cs) begin
        if (!cs_prev) begin
          cur.addr = bus.bus2ip_addr; cur.rnw = bus.bus2ip_rnw;
          cur.data = bus.bus2ip_data; cur.be  = bus.bus2ip_be; cur.len = 0;
        end
        cur.len++;
        ack = (sl_delay != 0) && (cur.len == sl_delay);
        bus.ip2bus_rdack = (ack && cur.rnw) || (sl_stray && !cur.rnw && !ack);
        bus.ip2bus_wrack = ack && !cur.rnw;
        bus.ip2bus_error = ack ? sl_err : 1'($urandom_range(0, 1));
        bus.ip2bus_data  = $urandom();
        if (ack && cur.rnw) bus.ip2bus_data = smem.exists(cur.addr) ? smem[cur.addr] : dflt(cur.addr);
        if (ack && !cur.rnw && !sl_err) begin
          v = smem.exists(cur.addr) ? smem[cur.addr] : dflt(cur.addr);
          for (int i = 0; i < 4; i++) if (cur.be[i]) v[8*i +: 8] = cur.data[8*i +: 8];
          smem[cur.addr] = v;
        end
      end else begin
        if (cs_prev) eps.push_back(cur);
        bus.ip2bus_rdack = 1'b0; bus.ip2bus_wrack = 1'b0;
        bus.ip2bus_error = 1'b0; bus.ip2bus_data  = $urandom();
      end
      cs_prev = bus.bus2ip_cs;
    end
  end

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int hold, output logic [1:0] r, output int lat);
    int n;
    logic bad;
    @(negedge clk);
    bus.s_axi_awaddr = a; bus.s_axi_wdata = d; bus.s_axi_wstrb = s;
    bus.s_axi_awvalid = 1'b1; bus.s_axi_wvalid = 1'b1;
    #1; n = 0;
    while (!(bus.s_axi_awready && bus.s_axi_wready) && n < 100) begin @(negedge clk); #1; n++; end
    n_tests++;
    if (n >= 100) begin n_fail++; $display("FAIL aw_handshake: no awready/wready within 100 cycles"); end
    @(posedge clk); #1;
    bus.s_axi_awvalid = 1'b0; bus.s_axi_wvalid = 1'b0;
    bus.s_axi_awaddr = $urandom(); bus.s_axi_wdata = $urandom();
    lat = 0;
    do begin @(negedge clk); lat++; end while (!bus.s_axi_bvalid && lat < 200);
    n_tests++;
    if (!bus.s_axi_bvalid) begin n_fail++; $display("FAIL bvalid_wait: no bvalid within 200 cycles"); end
    r = bus.s_axi_bresp; bad = 1'b0;
    repeat (hold) begin
      @(negedge clk);
      if (!bus.s_axi_bvalid || bus.s_axi_bresp !== r) bad = 1'b1;
    end
    n_tests++;
    if (bad) begin n_fail++; $display("FAIL bvalid_hold: bvalid/bresp changed while bready low, bresp=%b", r); end
    bus.s_axi_bready = 1'b1;
    @(posedge clk); #1;
    bus.s_axi_bready = 1'b0;
    n_tests++;
    if (bus.s_axi_bvalid !== 1'b0) begin n_fail++; $display("FAIL bvalid_drop: got %b want 0", bus.s_axi_bvalid); end
  endtask

  task automatic axi_read(input logic [31:0] a, input int hold,
                          output logic [31:0] d, output logic [1:0] r, output int lat);
    int n;
    logic bad;
    @(negedge clk);
    bus.s_axi_araddr = a; bus.s_axi_arvalid = 1'b1;
    #1; n = 0;
    while (!bus.s_axi_arready && n < 100) begin @(negedge clk); #1; n++; end
    n_tests++;
    if (n >= 100) begin n_fail++; $display("FAIL ar_handshake: no arready within 100 cycles"); end
    @(posedge clk); #1;
    bus.s_axi_arvalid = 1'b0; bus.s_axi_araddr = $urandom();
    lat = 0;
    do begin @(negedge clk); lat++; end while (!bus.s_axi_rvalid && lat < 200);
    n_tests++;
    if (!bus.s_axi_rvalid) begin n_fail++; $display("FAIL rvalid_wait: no rvalid within 200 cycles"); end
    d = bus.s_axi_rdata; r = bus.s_axi_rresp; bad = 1'b0;
    repeat (hold) begin
      @(negedge clk);
      if (!bus.s_axi_rvalid || bus.s_axi_rdata !== d || bus.s_axi_rresp !== r) bad = 1'b1;
    end
    n_tests++;
    if (bad) begin n_fail++; $display("FAIL rvalid_hold: rvalid/rdata/rresp changed while rready low, rdata=%h", d); end
    bus.s_axi_rready = 1'b1;
    @(posedge clk); #1;
    bus.s_axi_rready = 1'b0;
    n_tests++;
    if (bus.s_axi_rvalid !== 1'b0) begin n_fail++; $display("FAIL rvalid_drop: got %b want 0", bus.s_axi_rvalid); end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_tests++;
    if ({bus.s_axi_awready, bus.s_axi_wready, bus.s_axi_arready, bus.s_axi_bvalid, bus.s_axi_rvalid} !== 5'b0) begin
      n_fail++; $display("FAIL reset_handshake: ready/valid=%b want 00000",
        {bus.s_axi_awready, bus.s_axi_wready, bus.s_axi_arready, bus.s_axi_bvalid, bus.s_axi_rvalid});
    end
    n_tests++;
    if ({bus.s_axi_bresp, bus.s_axi_rresp} !== 4'b0 || bus.s_axi_rdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_resp: bresp=%b rresp=%b rdata=%h want 0", bus.s_axi_bresp, bus.s_axi_rresp, bus.s_axi_rdata);
    end
    n_tests++;
    if (bus.bus2ip_cs !== 1'b0 || bus.bus2ip_rnw !== 1'b1 || bus.bus2ip_addr !== 32'h0 ||
        bus.bus2ip_data !== 32'h0 || bus.bus2ip_be !== 4'h0) begin
      n_fail++; $display("FAIL reset_ipif: cs=%b rnw=%b addr=%h data=%h be=%h want cs=0 rnw=1 rest 0",
        bus.bus2ip_cs, bus.bus2ip_rnw, bus.bus2ip_addr, bus.bus2ip_data, bus.bus2ip_be);
    end
    rst = 1'b0;
  endtask

  // All three requests raised together; read_first says which must win.
  task automatic test_arbitration(input logic from_reset, input logic read_first);
    logic [31:0] wa, wd, ra, rd_got, rd_exp;
    logic [1:0]  rr, br;
    int          lat, base, got_r, got_b, n;
    logic        both, rd_done, wr_done;
    string       order;
    wa = BASE + 32'h40; ra = BASE + 32'h44; wd = $urandom();
    sl_delay = 1; sl_err = 1'b0;
    if (!from_reset) axi_read(ra, 0, rd_got, rr, lat);
    rd_exp = model_rd(ra);
    @(negedge clk);
    if (from_reset) rst = 1'b1;
    bus.s_axi_awaddr = wa; bus.s_axi_wdata = wd; bus.s_axi_wstrb = 4'hF; bus.s_axi_araddr = ra;
    bus.s_axi_awvalid = 1'b1; bus.s_axi_wvalid = 1'b1; bus.s_axi_arvalid = 1'b1;
    bus.s_axi_bready = 1'b1; bus.s_axi_rready = 1'b1;
    if (from_reset) begin
      #1;
      n_tests++;
      if ({bus.s_axi_awready, bus.s_axi_wready, bus.s_axi_arready} !== 3'b0) begin
        n_fail++; $display("FAIL reset_ready_masked: got %b want 000", {bus.s_axi_awready, bus.s_axi_wready, bus.s_axi_arready});
      end
      @(negedge clk); rst = 1'b0;
    end
    base = eps.size(); order = ""; got_r = 0; got_b = 0; both = 1'b0;
    rd_done = 1'b0; wr_done = 1'b0; n = 0;
    while ((got_r == 0 || got_b == 0) && n < 60) begin
      #1;
      if (bus.s_axi_arready && bus.s_axi_awready) both = 1'b1;
      rd_done = bus.s_axi_arvalid && bus.s_axi_arready;
      wr_done = bus.s_axi_awvalid && bus.s_axi_awready && bus.s_axi_wready;
      if (rd_done) order = {order, "R"};
      if (wr_done) order = {order, "W"};
      if (bus.s_axi_rvalid) begin got_r++; rd_got = bus.s_axi_rdata; rr = bus.s_axi_rresp; end
      if (bus.s_axi_bvalid) begin got_b++; br = bus.s_axi_bresp; end
      @(posedge clk); #1;
      if (rd_done) bus.s_axi_arvalid = 1'b0;
      if (wr_done) begin bus.s_axi_awvalid = 1'b0; bus.s_axi_wvalid = 1'b0; end
      @(negedge clk); n++;
    end
    bus.s_axi_bready = 1'b0; bus.s_axi_rready = 1'b0;
    @(negedge clk);
    n_tests++;
    if (order != (read_first ? "RW" : "WR")) begin
      n_fail++; $display("FAIL arb_order: got \"%s\" want \"%s\"", order, read_first ? "RW" : "WR");
    end
    n_tests++;
    if (got_r != 1 || got_b != 1 || both) begin
      n_fail++; $display("FAIL arb_responses: rresp_count=%0d bresp_count=%0d dual_grant=%b want 1 1 0", got_r, got_b, both);
    end
    n_tests++;
    if (eps.size() - base != 2 || eps[base].rnw !== read_first) begin
      n_fail++; $display("FAIL arb_cs_episodes: count=%0d want 2 (first rnw should be %b)", eps.size() - base, read_first);
    end
    n_tests++;
    if (rd_got !== rd_exp || rr !== 2'b00 || br !== 2'b00) begin
      n_fail++; $display("FAIL arb_data: rdata=%h rresp=%b bresp=%b want %h 00 00", rd_got, rr, br, rd_exp);
    end
    model_wr(wa, wd, 4'hF);
  endtask

  task automatic test_write_basic();
    logic [1:0] r;
    int lat, base;
    sl_delay = 1; base = eps.size();
    axi_write(32'h10 + BASE - 32'h100 + 32'h100, 32'hA5A5_A5A5, 4'hF, 0, r, lat);
    n_tests++;
    if (r !== 2'b00 || lat != 2) begin n_fail++; $display("FAIL write_basic_resp: bresp=%b lat=%0d want 00 2", r, lat); end
    n_tests++;
    if (eps.size() - base != 1 || eps[base].len != 1 || eps[base].rnw !== 1'b0 || eps[base].be !== 4'hF ||
        eps[base].addr !== BASE + 32'h10 || eps[base].data !== 32'hA5A5_A5A5) begin
      n_fail++; $display("FAIL write_basic_ipif: episodes=%0d len=%0d rnw=%b be=%h addr=%h data=%h want 1 1 0 f %h a5a5a5a5",
        eps.size() - base, eps[base].len, eps[base].rnw, eps[base].be, eps[base].addr, eps[base].data, BASE + 32'h10);
    end
    model_wr(BASE + 32'h10, 32'hA5A5_A5A5, 4'hF);
  endtask

  task automatic test_read_hold();
    logic [31:0] d;
    logic [1:0]  r;
    int lat, base;
    smem[BASE + 32'h14] = 32'h1234_5678; mmem[BASE + 32'h14] = 32'h1234_5678;
    sl_delay = 3; base = eps.size();
    axi_read(BASE + 32'h14, 5, d, r, lat);
    n_tests++;
    if (d !== 32'h1234_5678 || r !== 2'b00 || lat != 4) begin
      n_fail++; $display("FAIL read_hold_resp: rdata=%h rresp=%b lat=%0d want 12345678 00 4", d, r, lat);
    end
    n_tests++;
    if (eps.size() - base != 1 || eps[base].len != 3 || eps[base].rnw !== 1'b1 || eps[base].be !== 4'hF) begin
      n_fail++; $display("FAIL read_hold_cs: episodes=%0d len=%0d rnw=%b be=%h want 1 3 1 f",
        eps.size() - base, eps[base].len, eps[base].rnw, eps[base].be);
    end
  endtask

  task automatic test_decode();
    logic [31:0] addrs [6];
    logic [31:0] d;
    logic [1:0]  r, want;
    logic        inr;
    int lat, base;
    addrs = '{BASE - 32'h4, BASE, HIGH, HIGH + 32'h1, HIGH + 32'h4, 32'hFFFF_FFFC};
    sl_delay = 1;
    foreach (addrs[i]) begin
      inr = (addrs[i] >= BASE) && (addrs[i] <= HIGH);
      want = inr ? 2'b00 : 2'b11;
      base = eps.size();
      axi_read(addrs[i], 1, d, r, lat);
      n_tests++;
      if (r !== want || (eps.size() - base) != (inr ? 1 : 0) || lat != (inr ? 2 : 1) ||
          d !== (inr ? model_rd(addrs[i]) : 32'h0)) begin
        n_fail++; $display("FAIL decode_rd[%h]: rresp=%b episodes=%0d lat=%0d rdata=%h want %b %0d %0d",
          addrs[i], r, eps.size() - base, lat, d, want, inr ? 1 : 0, inr ? 2 : 1);
      end
    end
    base = eps.size();
    axi_write(HIGH + 32'h4, 32'hCAFE_F00D, 4'hF, 2, r, lat);
    n_tests++;
    if (r !== 2'b11 || eps.size() != base || lat != 1) begin
      n_fail++; $display("FAIL decode_wr: bresp=%b episodes=%0d lat=%0d want 11 0 1", r, eps.size() - base, lat);
    end
  endtask

  task automatic test_error();
    logic [31:0] d;
    logic [1:0]  r;
    int lat, base;
    sl_err = 1'b1; sl_stray = 1'b1; sl_delay = 3; base = eps.size();
    axi_write(BASE + 32'h80, 32'h1111_2222, 4'h3, 1, r, lat);
    n_tests++;
    if (r !== 2'b10 || lat != 4 || eps.size() - base != 1 || eps[base].len != 3) begin
      n_fail++; $display("FAIL error_wr: bresp=%b lat=%0d len=%0d want 10 4 3 (stray rdack must be ignored)",
        r, lat, eps[base].len);
    end
    sl_stray = 1'b0; sl_delay = 2;
    axi_read(BASE + 32'h84, 0, d, r, lat);
    n_tests++;
    if (r !== 2'b10 || d !== model_rd(BASE + 32'h84)) begin
      n_fail++; $display("FAIL error_rd: rresp=%b rdata=%h want 10 %h", r, d, model_rd(BASE + 32'h84));
    end
    sl_err = 1'b0;
  endtask

`ifdef IPIF_TIMEOUT_EN
  task automatic test_timeout();
    logic [31:0] d;
    logic [1:0]  r;
    int lat, base;
    sl_delay = 0; base = eps.size();
    axi_read(BASE + 32'hA0, 1, d, r, lat);
    n_tests++;
    if (r !== 2'b10 || d !== 32'hDEAD_BEEF || lat != 9 || eps[base].len != 8) begin
      n_fail++; $display("FAIL timeout_rd: rresp=%b rdata=%h lat=%0d cs_len=%0d want 10 deadbeef 9 8",
        r, d, lat, eps[base].len);
    end
    base = eps.size();
    axi_write(BASE + 32'hA4, 32'h5555_AAAA, 4'hF, 0, r, lat);
    n_tests++;
    if (r !== 2'b10 || eps[base].len != 8) begin
      n_fail++; $display("FAIL timeout_wr: bresp=%b cs_len=%0d want 10 8", r, eps[base].len);
    end
    sl_delay = 1;
  endtask
`endif

  task automatic test_reset_mid();
    logic [31:0] d;
    logic [1:0]  r;
    int lat, base, n;
    sl_delay = 0;
    @(negedge clk);
    bus.s_axi_araddr = BASE + 32'h20; bus.s_axi_arvalid = 1'b1;
    #1; n = 0;
    while (!bus.s_axi_arready && n < 50) begin @(negedge clk); #1; n++; end
    @(posedge clk); #1; bus.s_axi_arvalid = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if (bus.bus2ip_cs !== 1'b1) begin n_fail++; $display("FAIL reset_mid_pre: cs=%b want 1", bus.bus2ip_cs); end
    #3 rst = 1'b1;
    #1;
    n_tests++;
    if (bus.bus2ip_cs !== 1'b0 || bus.s_axi_rvalid !== 1'b0 || bus.bus2ip_rnw !== 1'b1 || bus.bus2ip_addr !== 32'h0) begin
      n_fail++; $display("FAIL reset_mid_async: cs=%b rvalid=%b rnw=%b addr=%h want 0 0 1 0",
        bus.bus2ip_cs, bus.s_axi_rvalid, bus.bus2ip_rnw, bus.bus2ip_addr);
    end
    @(negedge clk); rst = 1'b0;
    sl_delay = 2; base = eps.size();
    axi_read(BASE + 32'h24, 0, d, r, lat);
    n_tests++;
    if (d !== model_rd(BASE + 32'h24) || r !== 2'b00 || lat != 3 || eps.size() - base != 1) begin
      n_fail++; $display("FAIL reset_mid_after: rdata=%h rresp=%b lat=%0d episodes=%0d want %h 00 3 1",
        d, r, lat, eps.size() - base, model_rd(BASE + 32'h24));
    end
  endtask

  task automatic test_random(input int count);
    logic [31:0] a, wd, d, exp_d;
    logic [3:0]  s;
    logic [1:0]  r, exp_r;
    logic        rnw, inr;
    int lat, base, hold;
    for (int k = 0; k < count; k++) begin
      rnw = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 5) == 0) begin
        case ($urandom_range(0, 3))
          0: a = BASE - 32'h4;
          1: a = HIGH + 32'h1;
          2: a = 32'h0;
          default: a = 32'h8000_0000 | (32'($urandom_range(0, 255)) << 2);
        endcase
      end else a = BASE + (32'($urandom_range(0, 63)) << 2);
      wd = $urandom(); s = 4'($urandom_range(0, 15));
      sl_delay = $urandom_range(1, 4); sl_err = ($urandom_range(0, 5) == 0);
      hold = $urandom_range(0, 3);
      inr = (a >= BASE) && (a <= HIGH);
      exp_r = !inr ? 2'b11 : (sl_err ? 2'b10 : 2'b00);
      exp_d = inr ? model_rd(a) : 32'h0;
      base = eps.size();
      if (rnw) axi_read(a, hold, d, r, lat);
      else     axi_write(a, wd, s, hold, r, lat);
      n_tests++;
      if (r !== exp_r || lat != (inr ? sl_delay + 1 : 1)) begin
        n_fail++; $display("FAIL rand[%0d] resp: rnw=%b addr=%h resp=%b lat=%0d want %b %0d",
          k, rnw, a, r, lat, exp_r, inr ? sl_delay + 1 : 1);
      end
      n_tests++;
      if (eps.size() - base != (inr ? 1 : 0)) begin
        n_fail++; $display("FAIL rand[%0d] episodes: got %0d want %0d", k, eps.size() - base, inr ? 1 : 0);
      end else if (inr) begin
        n_tests++;
        if (eps[base].addr !== a || eps[base].rnw !== rnw || eps[base].len != sl_delay ||
            eps[base].be !== (rnw ? 4'hF : s) || (!rnw && eps[base].data !== wd)) begin
          n_fail++; $display("FAIL rand[%0d] ipif: addr=%h rnw=%b len=%0d be=%h data=%h want %h %b %0d %h %h",
            k, eps[base].addr, eps[base].rnw, eps[base].len, eps[base].be, eps[base].data,
            a, rnw, sl_delay, rnw ? 4'hF : s, wd);
        end
      end
      if (rnw) begin
        n_tests++;
        if (d !== exp_d) begin n_fail++; $display("FAIL rand[%0d] rdata: addr=%h got %h want %h", k, a, d, exp_d); end
      end else if (exp_r == 2'b00) model_wr(a, wd, s);
    end
    sl_err = 1'b0;
  endtask

  initial begin
    bus.s_axi_awaddr = '0; bus.s_axi_awvalid = 1'b0; bus.s_axi_wdata = '0; bus.s_axi_wstrb = '0;
    bus.s_axi_wvalid = 1'b0; bus.s_axi_bready = 1'b0; bus.s_axi_araddr = '0;
    bus.s_axi_arvalid = 1'b0; bus.s_axi_rready = 1'b0;
    test_reset();
    test_arbitration(1'b1, 1'b1);
    test_arbitration(1'b0, 1'b0);
    test_write_basic();
    test_read_hold();
    test_decode();
    test_error();
`ifdef IPIF_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    test_random(40);
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "time limit");
  end
endmodule
